// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg
// Shared types and defaults for the framebuffer reader:
//   HDISP_DEF / VDISP_DEF        default active frame geometry
//   FIFO_DEPTH_DEF / MAX_RUN_DEF default FIFO depth and Wishbone run length
//   rgb_t                        24-bit pixel colour
//   fb_word_t                    FIFO entry: start-of-frame flag + colour
//   fb_state_t                   Wishbone master FSM states
// ---------------------------------------------------------------------------
package fb_pkg;

    localparam int unsigned HDISP_DEF      = 800;
    localparam int unsigned VDISP_DEF      = 480;
    localparam int unsigned FIFO_DEPTH_DEF = 256;
    localparam int unsigned MAX_RUN_DEF    = 64;

    typedef logic [23:0] rgb_t;

    typedef struct packed {
        logic sof;
        rgb_t rgb;
    } fb_word_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        GAP
    } fb_state_t;

endpackage

// File: rtl/fb_reader_if.sv
// ---------------------------------------------------------------------------
// fb_reader_if
// Bundles the Wishbone read-master bus and the display-side pixel stream of
// fb_reader.
//   master modport : the reader (drives wshb_* requests and pix_* stream)
//   slave modport  : interconnect/consumer side (drives dat_sm, ack, ready)
// Signals:
//   wshb_cyc/stb/we/sel/cti/bte/adr  Wishbone request
//   wshb_dat_sm, wshb_ack            Wishbone read data / acknowledge
//   pix_data, pix_sof, pix_valid     head pixel of the stream
//   pix_ready                        consumer accepts the head pixel
// ---------------------------------------------------------------------------
interface fb_reader_if;
    import fb_pkg::*;

    logic        wshb_cyc;
    logic        wshb_stb;
    logic        wshb_we;
    logic [3:0]  wshb_sel;
    logic [2:0]  wshb_cti;
    logic [1:0]  wshb_bte;
    logic [31:0] wshb_adr;
    logic [31:0] wshb_dat_sm;
    logic        wshb_ack;

    rgb_t        pix_data;
    logic        pix_sof;
    logic        pix_valid;
    logic        pix_ready;

    modport master (
        output wshb_cyc, wshb_stb, wshb_we, wshb_sel, wshb_cti, wshb_bte, wshb_adr,
        input  wshb_dat_sm, wshb_ack,
        output pix_data, pix_sof, pix_valid,
        input  pix_ready
    );

    modport slave (
        input  wshb_cyc, wshb_stb, wshb_we, wshb_sel, wshb_cti, wshb_bte, wshb_adr,
        output wshb_dat_sm, wshb_ack,
        input  pix_data, pix_sof, pix_valid,
        output pix_ready
    );

endinterface

// File: rtl/fb_fifo.sv
// ---------------------------------------------------------------------------
// fb_fifo
// Synchronous first-word-fall-through FIFO of fb_word_t entries.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (empties the FIFO)
//   push         write wr_data (must not be asserted while full)
//   wr_data      entry to write
//   pop          consume head entry (ignored while empty)
//   rd_data      head entry, valid whenever !empty
//   empty, full  occupancy flags
//   count        number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
module fb_fifo
    import fb_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  fb_word_t               wr_data,
    input  logic                   pop,
    output fb_word_t               rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fb_word_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_pop;

    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign rd_data = mem[rd_ptr];

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

    no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/fb_reader.sv
// ---------------------------------------------------------------------------
// fb_reader
// Wishbone classic read master that fetches the framebuffer in raster order
// (HDISP x VDISP pixels, wrapping endlessly), buffers the pixels in a FWFT
// FIFO and presents them as a valid/ready stream with a start-of-frame flag.
// Ports:
//   clk    system / Wishbone clock
//   rst_n  asynchronous active-low reset
//   bus    fb_reader_if.master: Wishbone request/response and pixel stream
// At most one access is outstanding; cyc/stb drop for one cycle after every
// MAX_RUN acknowledges, and are never raised while the FIFO is full.
// ---------------------------------------------------------------------------
module fb_reader
    import fb_pkg::*;
#(
    parameter int unsigned HDISP      = HDISP_DEF,
    parameter int unsigned VDISP      = VDISP_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned MAX_RUN    = MAX_RUN_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    fb_reader_if.master bus
);

    localparam int unsigned PW = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int unsigned LW = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam int unsigned RW = $clog2(MAX_RUN + 1);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [PW-1:0] PIX_LAST  = PW'(HDISP - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(VDISP - 1);
    localparam logic [RW-1:0] RUN_MAX   = RW'(MAX_RUN);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    fb_state_t      state;
    fb_state_t      state_next;
    logic [31:0]    adr;
    logic [PW-1:0]  pixel_cpt;
    logic [LW-1:0]  line_cpt;
    logic [RW-1:0]  run_cnt;
    logic [RW-1:0]  run_inc;

    logic           push;
    logic           pop;
    fb_word_t       wr_word;
    fb_word_t       head;
    logic           fifo_empty;
    logic           fifo_full;
    logic [CW-1:0]  fifo_count;
    logic [CW-1:0]  cnt_after;

    fb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (wr_word),
        .pop     (pop),
        .rd_data (head),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    assign push    = (state == READ) && bus.wshb_ack;
    assign pop     = !fifo_empty && bus.pix_ready;
    assign run_inc = run_cnt + 1'b1;

    assign wr_word = '{sof: (pixel_cpt == '0) && (line_cpt == '0),
                       rgb: bus.wshb_dat_sm[23:0]};

    always_comb begin
        cnt_after = fifo_count;
        if (push && !pop) begin
            cnt_after = fifo_count + 1'b1;
        end else if (!push && pop) begin
            cnt_after = fifo_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Run-length gap takes priority over stopping on a full FIFO.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (fifo_count < FULL_CNT) begin
                    state_next = READ;
                end
            end
            READ: begin
                if (push) begin
                    if (run_inc == RUN_MAX) begin
                        state_next = GAP;
                    end else if (cnt_after == FULL_CNT) begin
                        state_next = IDLE;
                    end
                end
            end
            GAP: begin
                state_next = (fifo_count < FULL_CNT) ? READ : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The byte address is kept as a running sum instead of
    // (HDISP*line_cpt + pixel_cpt)*4; it returns to 0 with the frame wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adr       <= '0;
            pixel_cpt <= '0;
            line_cpt  <= '0;
            run_cnt   <= '0;
        end else if (push) begin
            run_cnt <= (run_inc == RUN_MAX) ? '0 : run_inc;
            if (pixel_cpt == PIX_LAST) begin
                pixel_cpt <= '0;
                if (line_cpt == LINE_LAST) begin
                    line_cpt <= '0;
                    adr      <= '0;
                end else begin
                    line_cpt <= line_cpt + 1'b1;
                    adr      <= adr + 32'd4;
                end
            end else begin
                pixel_cpt <= pixel_cpt + 1'b1;
                adr       <= adr + 32'd4;
            end
        end
    end

    assign bus.wshb_cyc = (state == READ);
    assign bus.wshb_stb = (state == READ);
    assign bus.wshb_we  = 1'b0;
    assign bus.wshb_sel = '1;
    assign bus.wshb_cti = '0;
    assign bus.wshb_bte = '0;
    assign bus.wshb_adr = adr;

    // Head storage is not reset, so the stream outputs are forced to 0
    // whenever nothing valid is at the head.
    assign bus.pix_valid = !fifo_empty;
    assign bus.pix_data  = fifo_empty ? '0 : head.rgb;
    assign bus.pix_sof   = !fifo_empty && head.sof;

endmodule

// File: tb/tb_fb_reader.sv
// ---------------------------------------------------------------------------
// tb_fb_reader
// Self-checking bench for fb_reader with a reduced frame (40x10). A queue
// model of the pixel stream and the bus rules is checked every cycle at the
// falling edge; directed phases pin specific literal values.
// ---------------------------------------------------------------------------
module tb_fb_reader;
    import fb_pkg::*;

    localparam int unsigned H     = 40;
    localparam int unsigned V     = 10;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned RUN   = 64;
    localparam int unsigned FRAME = H * V;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    fb_reader_if bus ();

    fb_reader #(
        .HDISP      (H),
        .VDISP      (V),
        .FIFO_DEPTH (DEPTH),
        .MAX_RUN    (RUN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- stimulus driver (inputs change 1ns after posedge) ----
    int unsigned ack_mode   = 0;  // 0: ack whenever stb, 1: every 3rd cycle, 2: random
    int unsigned ready_mode = 1;  // 0: never, 1: always, 2: random
    bit          dat_index  = 1'b1; // data low 24 bits = adr>>2, else fully random
    int unsigned cyc_n      = 0;

    initial begin
        bus.wshb_ack    = 1'b0;
        bus.wshb_dat_sm = '0;
        bus.pix_ready   = 1'b0;
    end

    always @(posedge clk) begin
        logic [31:0] r;
        #1;
        cyc_n++;
        r = $urandom();
        case (ack_mode)
            0:       bus.wshb_ack = bus.wshb_stb;
            1:       bus.wshb_ack = bus.wshb_stb && (cyc_n % 3 == 0);
            default: bus.wshb_ack = ($urandom_range(0, 2) != 0);
        endcase
        if (dat_index) bus.wshb_dat_sm = {r[7:0], 24'(bus.wshb_adr >> 2)};
        else           bus.wshb_dat_sm = r;
        case (ready_mode)
            0:       bus.pix_ready = 1'b0;
            1:       bus.pix_ready = 1'b1;
            default: bus.pix_ready = ($urandom_range(0, 1) == 1);
        endcase
    end

    // ---------------- reference model and per-cycle compare ---------------
    fb_word_t    q[$];
    int unsigned acks    = 0;  // accepted reads since reset
    int unsigned runs    = 0;  // accepted reads since last gap
    logic        exp_stb = 1'b0;

    always @(negedge clk) begin
        int unsigned sz;
        int unsigned sz_after;
        bit          pop;
        bit          push;
        if (!rst_n) begin
            q.delete();
            acks    = 0;
            runs    = 0;
            exp_stb = 1'b0;
        end else begin
            sz = q.size();
            check("cyc_eq_stb", 64'(bus.wshb_cyc), 64'(bus.wshb_stb));
            check("stb_timing", 64'(bus.wshb_stb), 64'(exp_stb));
            check("pix_valid", 64'(bus.pix_valid), 64'(sz != 0));
            if (sz != 0) begin
                check("pix_data", 64'(bus.pix_data), 64'(q[0].rgb));
                check("pix_sof", 64'(bus.pix_sof), 64'(q[0].sof));
            end
            if (bus.wshb_stb) check("adr", 64'(bus.wshb_adr), 64'((acks % FRAME) * 4));
            pop      = (sz != 0) && bus.pix_ready;
            push     = bus.wshb_stb && bus.wshb_ack;
            sz_after = sz + (push ? 1 : 0) - (pop ? 1 : 0);
            if (push) begin
                runs++;
                if (runs == RUN) begin
                    runs    = 0;
                    exp_stb = 1'b0;
                end else begin
                    exp_stb = (sz_after < DEPTH);
                end
            end else if (bus.wshb_stb) begin
                exp_stb = 1'b1;
            end else begin
                exp_stb = (sz < DEPTH);
            end
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(fb_word_t'{sof: ((acks % FRAME) == 0), rgb: bus.wshb_dat_sm[23:0]});
                acks++;
            end
        end
    end

    // ---------------- directed phases ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cyc"}, 64'(bus.wshb_cyc), 64'(0));
        check({tag, "_stb"}, 64'(bus.wshb_stb), 64'(0));
        check({tag, "_adr"}, 64'(bus.wshb_adr), 64'(0));
        check({tag, "_valid"}, 64'(bus.pix_valid), 64'(0));
        check({tag, "_data"}, 64'(bus.pix_data), 64'(0));
        check({tag, "_sof"}, 64'(bus.pix_sof), 64'(0));
    endtask

    initial begin
        int unsigned n;
        bit          found;
        logic [31:0] held;

        // Test 1: reset values, first pixels and latency
        #2 rst_n = 1'b0;
        tick();
        check_reset_values("reset");
        tick();
        @(posedge clk);
        #3 rst_n = 1'b1;
        found = 0;
        for (n = 0; n < 5 && !found; n++) begin
            tick();
            found = bus.wshb_stb;
        end
        check("t1_first_stb_seen", 64'(found), 64'(1));
        check("t1_first_adr", 64'(bus.wshb_adr), 64'(0));
        check("t1_empty_before_ack", 64'(bus.pix_valid), 64'(0));
        check("t1_we", 64'(bus.wshb_we), 64'(0));
        check("t1_sel", 64'(bus.wshb_sel), 64'(4'hf));
        check("t1_cti", 64'(bus.wshb_cti), 64'(0));
        check("t1_bte", 64'(bus.wshb_bte), 64'(0));
        tick();
        check("t1_adr1", 64'(bus.wshb_adr), 64'(4));
        check("t1_pix0_valid", 64'(bus.pix_valid), 64'(1));
        check("t1_pix0_data", 64'(bus.pix_data), 64'(0));
        check("t1_pix0_sof", 64'(bus.pix_sof), 64'(1));
        tick();
        check("t1_adr2", 64'(bus.wshb_adr), 64'(8));
        check("t1_pix1_data", 64'(bus.pix_data), 64'(1));
        check("t1_pix1_sof", 64'(bus.pix_sof), 64'(0));

        // Test 3: one-cycle gap after the 64th ack
        found = 0;
        for (n = 0; n < 100 && !found; n++) begin
            tick();
            found = !bus.wshb_stb;
        end
        check("t3_gap_seen", 64'(found), 64'(1));
        check("t3_acks_at_gap", 64'(acks), 64'(64));
        tick();
        check("t3_stb_after_gap", 64'(bus.wshb_stb), 64'(1));
        check("t3_adr_after_gap", 64'(bus.wshb_adr), 64'(256));

        // Test 2: consumer stalled, FIFO fills and reader stops
        @(posedge clk);
        ready_mode = 0;
        found = 0;
        for (n = 0; n < 600 && !found; n++) begin
            tick();
            found = (q.size() == DEPTH);
        end
        check("t2_fill_seen", 64'(found), 64'(1));
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_stb_stopped", 64'(bus.wshb_stb), 64'(0));
        end
        check("t2_model_count", 64'(q.size()), 64'(256));
        check("t2_fifo_count", 64'(dut.u_fifo.count), 64'(256));
        @(posedge clk);
        ready_mode = 1;
        found = 0;
        for (n = 0; n < 3 && !found; n++) begin
            tick();
            found = bus.wshb_stb;
        end
        check("t2_stb_reassert", 64'(found), 64'(1));

        // Test 5: slow slave, request held stable between acks
        @(posedge clk);
        ack_mode   = 1;
        ready_mode = 2;
        found = 0;
        for (n = 0; n < 20 && !found; n++) begin
            tick();
            found = bus.wshb_stb && !bus.wshb_ack;
        end
        check("t5_wait_seen", 64'(found), 64'(1));
        held = bus.wshb_adr;
        tick();
        check("t5_stb_held", 64'(bus.wshb_stb), 64'(1));
        check("t5_adr_held", 64'(bus.wshb_adr), 64'(held));
        repeat (300) tick();

        // Test 4: frame wrap back to address 0 with sof
        @(posedge clk);
        ack_mode   = 0;
        ready_mode = 1;
        found = 0;
        for (n = 0; n < 2000 && !found; n++) begin
            tick();
            found = bus.wshb_stb && (bus.wshb_adr == 32'((FRAME - 1) * 4));
        end
        check("t4_last_adr_seen", 64'(found), 64'(1));
        found = 0;
        for (n = 0; n < 4 && !found; n++) begin
            tick();
            found = bus.wshb_stb;
        end
        check("t4_wrap_adr", 64'(bus.wshb_adr), 64'(0));
        found = 0;
        for (n = 0; n < 600 && !found; n++) begin
            tick();
            found = bus.pix_valid && bus.pix_sof;
        end
        check("t4_sof_seen", 64'(found), 64'(1));
        check("t4_sof_data", 64'(bus.pix_data), 64'(0));

        // Test 6: reset mid-access with FIFO half full
        @(posedge clk);
        ready_mode = 0;
        found = 0;
        for (n = 0; n < 600 && !found; n++) begin
            tick();
            found = (q.size() >= DEPTH / 2) && bus.wshb_stb;
        end
        check("t6_half_full_seen", 64'(found), 64'(1));
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_reset_values("t6_async");
        @(posedge clk);
        @(posedge clk);
        ready_mode = 1;
        #3 rst_n = 1'b1;
        found = 0;
        for (n = 0; n < 5 && !found; n++) begin
            tick();
            found = bus.wshb_stb;
        end
        check("t6_restart_stb", 64'(found), 64'(1));
        check("t6_restart_adr", 64'(bus.wshb_adr), 64'(0));
        found = 0;
        for (n = 0; n < 5 && !found; n++) begin
            tick();
            found = bus.pix_valid;
        end
        check("t6_first_valid", 64'(found), 64'(1));
        check("t6_first_sof", 64'(bus.pix_sof), 64'(1));
        check("t6_first_data", 64'(bus.pix_data), 64'(0));

        // Random soak: random acks (also outside READ), random consumer
        @(posedge clk);
        ack_mode   = 2;
        ready_mode = 2;
        dat_index  = 1'b0;
        repeat (3000) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
